// File: rtl/mult4u_accum_stage.sv
// Block accumulator behind the 4-bit unsigned multiplier: sums BLOCK_LEN products, then holds the sum for a valid/ready consumer.
// Optional mod-3 product check is enabled by defining MULT4U_RESIDUE_CHECK_EN.
module mult4u_accum_stage #(
  parameter int ACC_W     = 12,
  parameter int BLOCK_LEN = 8,
  parameter int SATURATE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op_a,
  input  logic [3:0]       op_b,
  input  logic [7:0]       prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       beat_cnt,
  output logic             ovf,
  output logic             res_err
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [ACC_W-1:0] ACC_MAX     = '1;
  localparam logic [7:0]       BLOCK_LEN_C = 8'(BLOCK_LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W:0]   acc_sum;
  logic [7:0]       cnt_inc;
  logic             accept;
  logic             transfer;

  assign accept   = (state_q == ACCUM) && in_valid && !clear;
  assign transfer = (state_q == HOLD) && out_ready && !clear;
  assign acc_sum  = {1'b0, acc_q} + {{(ACC_W-7){1'b0}}, prod};
  assign cnt_inc  = cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Clear outranks both the beat handshake and the output transfer.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear || transfer) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      cnt_d = cnt_inc;
      if (acc_sum[ACC_W]) begin
        ovf_d = 1'b1;
        acc_d = (SATURATE != 0) ? ACC_MAX : acc_sum[ACC_W-1:0];
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
      if (cnt_inc == BLOCK_LEN_C) begin
        state_d = HOLD;
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  assign acc_out  = acc_q;
  assign beat_cnt = cnt_q;
  assign ovf      = ovf_q;

`ifdef MULT4U_RESIDUE_CHECK_EN
  logic res_err_q, res_err_d;
  logic res_mismatch;
  logic [1:0] res_a, res_b, res_p, res_ab;
  logic [3:0] res_ab_raw;

  // Base-4 digits each weigh 1 mod 3, so the residue is the folded digit sum.
  function automatic logic [1:0] mod3_8(input logic [7:0] v);
    logic [3:0] s1;
    logic [2:0] s2;
    logic [2:0] s3;
    s1 = {2'b00, v[1:0]} + {2'b00, v[3:2]} + {2'b00, v[5:4]} + {2'b00, v[7:6]};
    s2 = {1'b0, s1[1:0]} + {1'b0, s1[3:2]};
    s3 = {1'b0, s2[1:0]} + {2'b00, s2[2]};
    mod3_8 = (s3 >= 3'd3) ? 2'(s3 - 3'd3) : s3[1:0];
  endfunction

  always_comb begin
    res_a        = mod3_8({4'b0000, op_a});
    res_b        = mod3_8({4'b0000, op_b});
    res_p        = mod3_8(prod);
    res_ab_raw   = {2'b00, res_a} * {2'b00, res_b};
    res_ab       = mod3_8({4'b0000, res_ab_raw});
    res_mismatch = (res_p != res_ab);
  end

  always_comb begin
    res_err_d = res_err_q;
    if (clear || transfer) begin
      res_err_d = 1'b0;
    end else if (accept && res_mismatch) begin
      res_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_err_q <= 1'b0;
    end else begin
      res_err_q <= res_err_d;
    end
  end

  assign res_err = res_err_q;
`else
  logic unused_ops;
  assign unused_ops = ^{op_a, op_b};
  assign res_err    = 1'b0;
`endif

endmodule
